sc_4_point_ifft: RTL and testbench

Serial-commutator 4-point inverse transform for real signed two-lane frames. Each frame arrives as two samples per cycle over two cycles; the block returns the four time-domain samples in natural order, two per cycle, scaled by 1/4. It sits downstream of the team's 4-point serial-commutator forward transform. It reconstructs samples from the spectrum stream after processing. Unlike the forward block, it generates all commutator selects internally from a valid/frame-start handshake.

---
 rtl/sc_4_point_ifft_if.sv | 25 ++
 rtl/sc_4_point_ifft.sv | 154 +++++++++++++++
 tb/tb_sc_4_point_ifft.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sc_4_point_ifft_if.sv
// Handshake/data bundle for the serial-commutator 4-point inverse transform.
// master drives the spectrum words in; slave (the transform) returns time samples.
interface sc_4_point_ifft_if #(
  parameter int W = 6
) ();
  logic                in_valid;
  logic                frame_start;
  logic signed [W-1:0] in0;
  logic signed [W-1:0] in1;
  logic                out_valid;
  logic                out_idx;
  logic signed [W-1:0] out0;
  logic signed [W-1:0] out1;
  logic                resync;

  modport master (
    output in_valid, frame_start, in0, in1,
    input  out_valid, out_idx, out0, out1, resync
  );

  modport slave (
    input  in_valid, frame_start, in0, in1,
    output out_valid, out_idx, out0, out1, resync
  );
endinterface

// File: rtl/sc_4_point_ifft.sv
// Serial-commutator 4-point inverse transform: words A=(X0,X2), B=(X1,X3) in,
// time samples (x0,x1) then (x2,x3) out, scaled by 1/4 with floor.
module sc_4_point_ifft #(
  parameter int W = 6
) (
  input logic             clk,
  input logic             rst,
  sc_4_point_ifft_if.slave bus_io
);

  typedef enum logic [0:0] {StExpectA, StExpectB} state_e;

  state_e state_q, state_d;
  logic   take_a, take_b, discard;

  logic signed [W:0]   sum_s1, dif_s1;
  logic signed [W:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic                cd_valid_q, cd_valid_d;
  logic signed [W+1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic                y_valid_q, y_valid_d;
  logic                hi_pend_q, hi_pend_d;
  logic                out_valid_q, out_valid_d;
  logic                out_idx_q, out_idx_d;
  logic signed [W-1:0] out0_q, out0_d, out1_q, out1_d;
  logic                resync_q, resync_d;

  // Phase FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StExpectA;
    else     state_q <= state_d;
  end

  // Phase FSM: next state
  always_comb begin
    state_d = state_q;
    if (bus_io.in_valid) begin
      unique case (state_q)
        StExpectA: state_d = StExpectB;
        StExpectB: state_d = bus_io.frame_start ? StExpectB : StExpectA;
        default:   state_d = StExpectA;
      endcase
    end
  end

  // Phase FSM: decoded word role
  always_comb begin
    take_a  = 1'b0;
    take_b  = 1'b0;
    discard = 1'b0;
    if (bus_io.in_valid) begin
      unique case (state_q)
        StExpectA: take_a = 1'b1;
        StExpectB: begin
          take_a  = bus_io.frame_start;
          discard = bus_io.frame_start;
          take_b  = ~bus_io.frame_start;
        end
        default: take_a = 1'b1;
      endcase
    end
  end

  // Stage-1 lane butterfly, shared by words A and B
  always_comb begin
    sum_s1 = $signed({bus_io.in0[W-1], bus_io.in0}) + $signed({bus_io.in1[W-1], bus_io.in1});
    dif_s1 = $signed({bus_io.in0[W-1], bus_io.in0}) - $signed({bus_io.in1[W-1], bus_io.in1});
  end

  always_comb begin
    a_d         = take_a ? sum_s1 : a_q;
    b_d         = take_a ? dif_s1 : b_q;
    c_d         = take_b ? sum_s1 : c_q;
    d_d         = take_b ? dif_s1 : d_q;
    cd_valid_d  = take_b;
    resync_d    = discard;

    // Both stage-2 pairs are captured together so a following frame may
    // overwrite a/b/c/d while (b,d) results still wait to be issued.
    y0_d        = y0_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    y3_d        = y3_q;
    y_valid_d   = cd_valid_q;
    if (cd_valid_q) begin
      y0_d = $signed({a_q[W], a_q}) + $signed({c_q[W], c_q});
      y1_d = $signed({a_q[W], a_q}) - $signed({c_q[W], c_q});
      y2_d = $signed({b_q[W], b_q}) + $signed({d_q[W], d_q});
      y3_d = $signed({b_q[W], b_q}) - $signed({d_q[W], d_q});
    end

    out_valid_d = 1'b0;
    out_idx_d   = out_idx_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    hi_pend_d   = 1'b0;
    if (y_valid_q) begin
      out_valid_d = 1'b1;
      out_idx_d   = 1'b0;
      out0_d      = W'(y0_q >>> 2);
      out1_d      = W'(y1_q >>> 2);
      hi_pend_d   = 1'b1;
    end else if (hi_pend_q) begin
      out_valid_d = 1'b1;
      out_idx_d   = 1'b1;
      out0_d      = W'(y2_q >>> 2);
      out1_d      = W'(y3_q >>> 2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      cd_valid_q  <= 1'b0;
      y0_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      y3_q        <= '0;
      y_valid_q   <= 1'b0;
      hi_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
      resync_q    <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      cd_valid_q  <= cd_valid_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      y3_q        <= y3_d;
      y_valid_q   <= y_valid_d;
      hi_pend_q   <= hi_pend_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      resync_q    <= resync_d;
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_idx   = out_idx_q;
  assign bus_io.out0      = out0_q;
  assign bus_io.out1      = out1_q;
  assign bus_io.resync    = resync_q;

endmodule

// File: tb/tb_sc_4_point_ifft.sv
// Directed and table-driven bench for sc_4_point_ifft (W = 6).
module tb_sc_4_point_ifft;

  localparam int W = 6;

  typedef struct {
    string name;
    int    x0, x1, x2, x3;
    int    e0, e1, e2, e3;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  sc_4_point_ifft_if #(.W(W)) bus ();

  sc_4_point_ifft #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fs, input int i0, input int i1);
    bus.in_valid    = v;
    bus.frame_start = fs;
    bus.in0         = W'(i0);
    bus.in1         = W'(i1);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic eidx,
                         input int e0, input int e1);
    chk($sformatf("%s out_valid", tag), int'(bus.out_valid), int'(ev));
    if (ev) begin
      chk($sformatf("%s out_idx", tag), int'(bus.out_idx), int'(eidx));
      chk($sformatf("%s out0", tag), int'(bus.out0), e0);
      chk($sformatf("%s out1", tag), int'(bus.out1), e1);
    end
  endtask

  function automatic vec_t mk(input string n, input int x0, input int x1, input int x2,
                              input int x3, input int e0, input int e1, input int e2,
                              input int e3);
    vec_t v;
    v.name = n;
    v.x0 = x0; v.x1 = x1; v.x2 = x2; v.x3 = x3;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    return v;
  endfunction

  // Contiguous A/B at edges k, k+1; pairs expected after k+3 and k+4.
  task automatic run_frame(input vec_t v);
    drive(1'b1, 1'b1, v.x0, v.x2);
    tick();
    drive(1'b1, 1'b0, v.x1, v.x3);
    tick();
    drive(1'b0, 1'b0, 0, 0);
    tick();
    chk_out({v.name, " k+2"}, 1'b0, 1'b0, 0, 0);
    tick();
    chk_out({v.name, " p0"}, 1'b1, 1'b0, v.e0, v.e1);
    tick();
    chk_out({v.name, " p1"}, 1'b1, 1'b1, v.e2, v.e3);
    tick();
    chk_out({v.name, " after"}, 1'b0, 1'b0, 0, 0);
  endtask

  vec_t vecs[7];
  int   rx[10][4];
  int   ex[10][4];

  initial begin
    vecs[0] = mk("impulse",   4,   0,   0,   0,   1, 1,  1, 1);
    vecs[1] = mk("mixed",     8,   4,  -4,   0,   2, 0,  4, 2);
    vecs[2] = mk("floor_pos", 1,   0,   0,   0,   0, 0,  0, 0);
    vecs[3] = mk("floor_neg", -1,  0,   0,   0,  -1, -1, -1, -1);
    vecs[4] = mk("min_ext",  -32, -32, -32, -32, -32, 0,  0, 0);
    vecs[5] = mk("max_ext",   31,  31,  31,  31,  31, 0,  0, 0);
    vecs[6] = mk("asym",      5,  -3,   2,   7,   2, 0, -2, 3);

    drive(1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset out_idx", int'(bus.out_idx), 0);
    chk("reset out0", int'(bus.out0), 0);
    chk("reset out1", int'(bus.out1), 0);
    chk("reset resync", int'(bus.resync), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Gap between A and B: X = (5,1,2,-1) -> y = 7,7,5,1
    drive(1'b1, 1'b1, 5, 2);
    tick();
    drive(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("gap idle", 1'b0, 1'b0, 0, 0);
    end
    drive(1'b1, 1'b0, 1, -1);
    tick();
    drive(1'b0, 1'b0, 0, 0);
    tick();
    chk_out("gap m+1", 1'b0, 1'b0, 0, 0);
    tick();
    chk_out("gap p0", 1'b1, 1'b0, 1, 1);
    tick();
    chk_out("gap p1", 1'b1, 1'b1, 1, 0);
    tick();
    chk_out("gap after", 1'b0, 1'b0, 0, 0);

    // Resync: second A replaces the first; only (4,0)/(0,0) must reach the output.
    drive(1'b1, 1'b1, 10, 6);
    tick();
    chk("resync before", int'(bus.resync), 0);
    drive(1'b1, 1'b1, 4, 0);
    tick();
    chk("resync pulse", int'(bus.resync), 1);
    drive(1'b1, 1'b0, 0, 0);
    tick();
    chk("resync cleared", int'(bus.resync), 0);
    drive(1'b0, 1'b0, 0, 0);
    tick();
    chk_out("resync m+1", 1'b0, 1'b0, 0, 0);
    tick();
    chk_out("resync p0", 1'b1, 1'b0, 1, 1);
    tick();
    chk_out("resync p1", 1'b1, 1'b1, 1, 1);
    tick();
    chk_out("resync after", 1'b0, 1'b0, 0, 0);

    // Reset one cycle after B suppresses the frame entirely.
    drive(1'b1, 1'b1, 8, -4);
    tick();
    drive(1'b1, 1'b0, 4, 0);
    tick();
    drive(1'b0, 1'b0, 0, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst out_idx", int'(bus.out_idx), 0);
    chk("rst out0", int'(bus.out0), 0);
    chk("rst out1", int'(bus.out1), 0);
    chk("rst resync", int'(bus.resync), 0);
    tick();
    tick();
    chk_out("rst held", 1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("post rst", 1'b0, 1'b0, 0, 0);
    end

    // First word after reset is A even without frame_start.
    drive(1'b1, 1'b0, 4, 0);
    tick();
    drive(1'b1, 1'b0, 0, 0);
    tick();
    drive(1'b0, 1'b0, 0, 0);
    tick();
    chk_out("nofs k+2", 1'b0, 1'b0, 0, 0);
    tick();
    chk_out("nofs p0", 1'b1, 1'b0, 1, 1);
    tick();
    chk_out("nofs p1", 1'b1, 1'b1, 1, 1);
    tick();

    // Ten back-to-back random frames against a direct 4-point inverse model.
    for (int f = 0; f < 10; f++) begin
      for (int n = 0; n < 4; n++) rx[f][n] = int'($urandom_range(0, 63)) - 32;
      ex[f][0] = (rx[f][0] + rx[f][1] + rx[f][2] + rx[f][3]) >>> 2;
      ex[f][1] = (rx[f][0] - rx[f][1] + rx[f][2] - rx[f][3]) >>> 2;
      ex[f][2] = (rx[f][0] + rx[f][1] - rx[f][2] - rx[f][3]) >>> 2;
      ex[f][3] = (rx[f][0] - rx[f][1] - rx[f][2] + rx[f][3]) >>> 2;
    end
    drive(1'b1, 1'b1, rx[0][0], rx[0][2]);
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i >= 3 && i <= 22) begin
        int j, fr, h;
        j  = i - 3;
        fr = j / 2;
        h  = j % 2;
        chk_out($sformatf("b2b f%0d h%0d", fr, h), 1'b1, h[0], ex[fr][2*h], ex[fr][2*h+1]);
      end else begin
        chk_out($sformatf("b2b idle %0d", i), 1'b0, 1'b0, 0, 0);
      end
      if (i + 1 < 20) begin
        int w, fr;
        w  = i + 1;
        fr = w / 2;
        if (w % 2 == 0) drive(1'b1, 1'b1, rx[fr][0], rx[fr][2]);
        else            drive(1'b1, 1'b0, rx[fr][1], rx[fr][3]);
      end else begin
        drive(1'b0, 1'b0, 0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
